// File: rtl/stream_bram_loader_pkg.sv
// Shared types and derived constants for the stream-to-BRAM frame loader.
package stream_bram_loader_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_DISCARD = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Total words the banked buffer can hold.
  function automatic int cap_of(input int banks, input int depth);
    return banks * depth;
  endfunction

endpackage

// File: rtl/stream_bram_loader_bank_write_demux.sv
// Routes one write strobe to the bank chosen by the low beat-count bits and
// registers the per-bank BRAM port signals (idle banks keep addr/data).
module stream_bram_loader_bank_write_demux #(
  parameter int DATA_WIDTH_DATA = 16,
  parameter int DATA_BANKS      = 4,
  parameter int DATA_ADDR       = 8,
  parameter int DATA_WE         = 2,
  parameter int BSEL_W          = 2
) (
  input  logic                                        clk,
  input  logic                                        rstn,
  input  logic                                        i_wr,
  input  logic [BSEL_W+DATA_ADDR-1:0]                 i_cnt,
  input  logic [DATA_WIDTH_DATA-1:0]                  i_data,
  output logic [DATA_BANKS-1:0]                       o_en,
  output logic [DATA_BANKS-1:0][DATA_WE-1:0]          o_we,
  output logic [DATA_BANKS-1:0][DATA_ADDR-1:0]        o_addr,
  output logic [DATA_BANKS-1:0][DATA_WIDTH_DATA-1:0]  o_wrdata
);

  logic [BSEL_W-1:0]    w_sel;
  logic [DATA_ADDR-1:0] w_addr;
  logic [DATA_BANKS-1:0] w_hit;

  assign w_sel  = i_cnt[BSEL_W-1:0];
  assign w_addr = i_cnt[BSEL_W+DATA_ADDR-1:BSEL_W];
  assign w_hit  = i_wr ? (DATA_BANKS'(1) << w_sel) : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_en     <= '0;
      o_we     <= '0;
      o_addr   <= '0;
      o_wrdata <= '0;
    end else begin
      for (int b = 0; b < DATA_BANKS; b++) begin
        o_en[b] <= w_hit[b];
        o_we[b] <= {DATA_WE{w_hit[b]}};
        if (w_hit[b]) begin
          o_addr[b]   <= w_addr;
          o_wrdata[b] <= i_data;
        end
      end
    end
  end

endmodule

// File: rtl/stream_bram_loader.sv
// AXI-Stream slave that stripes one frame round-robin across the data banks,
// then holds the buffer (tready low) until the reader releases it.
module stream_bram_loader
  import stream_bram_loader_pkg::*;
#(
  parameter int DATA_WIDTH_DATA = 16,
  parameter int DATA_BANKS      = 4,
  parameter int DATA_BANK_DEPTH = 256,
  parameter int DATA_ADDR       = $clog2(DATA_BANK_DEPTH),
  parameter int DATA_WE         = DATA_WIDTH_DATA / 8,
  parameter int ID_WIDTH        = 8,
  parameter int DEST_WIDTH      = 8,
  parameter int USER_WIDTH      = 1,
  parameter int CNT_W           = $clog2(DATA_BANKS * DATA_BANK_DEPTH) + 1
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [DATA_WIDTH_DATA-1:0]            s_axis_tdata,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic                                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]                   s_axis_tid,
  input  logic [DEST_WIDTH-1:0]                 s_axis_tdest,
  input  logic [USER_WIDTH-1:0]                 s_axis_tuser,
  output logic [DATA_BANKS-1:0]                 mb_bram_en,
  output logic [DATA_BANKS*DATA_WE-1:0]         mb_bram_we,
  output logic [DATA_BANKS*DATA_ADDR-1:0]       mb_bram_addr,
  output logic [DATA_BANKS*DATA_WIDTH_DATA-1:0] mb_bram_wrdata,
  input  logic                                  buf_release,
  output logic                                  frame_done,
  output logic [CNT_W-1:0]                      frame_len,
  output logic                                  overflow
);

  localparam int BSEL_W = $clog2(DATA_BANKS);
  localparam int CAP    = cap_of(DATA_BANKS, DATA_BANK_DEPTH);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_frame_len, w_len_nxt;
  logic             r_overflow, w_ovf_nxt;
  logic             r_frame_done, w_done_nxt;
  logic             w_tready, w_acc, w_room, w_wr;
  logic             w_unused;

  // Sideband fields are accepted but carry no meaning for the buffer.
  assign w_unused = ^{s_axis_tid, s_axis_tdest, s_axis_tuser};

  assign w_tready = (r_state != ST_DONE) && rstn;
  assign w_acc    = s_axis_tvalid && w_tready;
  assign w_room   = r_cnt < CNT_W'(CAP);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_overflow;
    w_len_nxt   = r_frame_len;
    w_done_nxt  = 1'b0;
    w_wr        = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (w_acc) begin
          if (w_room) begin
            w_wr      = 1'b1;
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else begin
            w_ovf_nxt = 1'b1;
          end
          if (s_axis_tlast)  w_state_nxt = ST_DONE;
          else if (!w_room)  w_state_nxt = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (w_acc && s_axis_tlast) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (buf_release) begin
          w_state_nxt = ST_LOAD;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
    // cnt saturates at CAP, so the length captured here is already clamped.
    if (w_acc && s_axis_tlast) begin
      w_done_nxt = 1'b1;
      w_len_nxt  = w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ST_LOAD;
      r_cnt        <= '0;
      r_overflow   <= 1'b0;
      r_frame_len  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_overflow   <= w_ovf_nxt;
      r_frame_len  <= w_len_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  stream_bram_loader_bank_write_demux #(
    .DATA_WIDTH_DATA (DATA_WIDTH_DATA),
    .DATA_BANKS      (DATA_BANKS),
    .DATA_ADDR       (DATA_ADDR),
    .DATA_WE         (DATA_WE),
    .BSEL_W          (BSEL_W)
  ) u_demux (
    .clk      (clk),
    .rstn     (rstn),
    .i_wr     (w_wr),
    .i_cnt    (r_cnt[BSEL_W+DATA_ADDR-1:0]),
    .i_data   (s_axis_tdata),
    .o_en     (mb_bram_en),
    .o_we     (mb_bram_we),
    .o_addr   (mb_bram_addr),
    .o_wrdata (mb_bram_wrdata)
  );

  assign s_axis_tready = w_tready;
  assign frame_done    = r_frame_done;
  assign frame_len     = r_frame_len;
  assign overflow      = r_overflow;

endmodule
